// File: rtl/fifo_wptr_full.sv
// Write-domain half of an asynchronous FIFO: write pointer (binary and Gray), read-pointer
// synchroniser, and the full / almost-full / fill-level / overflow status seen by the writer.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int ALMOST_FULL_TH = 12
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wfill_level,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rq_pipe [SYNC_STAGES];
  logic [PW-1:0] rq_sync;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_match;
  logic [PW-1:0] level_next;
  logic          accept;

  // RAM-facing outputs depend only on flops and winc so they stay glitch-free for the RAM.
  assign accept     = winc & ~wfull;
  assign wclken     = accept;
  assign waddr      = wbin[ADDR_WIDTH-1:0];

  assign wbin_next  = wbin + PW'(accept);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  assign rq_sync    = rq_pipe[SYNC_STAGES-1];
  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_match = rq_sync ^ {2'b11, {(PW-2){1'b0}}};
  assign level_next = wbin_next - rbin_sync;

  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      rbin_sync[i] = ^(rq_sync >> i);
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wbin         <= '0;
      wptr_gray    <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wfill_level  <= '0;
      woverflow    <= 1'b0;
      // NOTE: the synchroniser chain is a handful of flops, not RAM, so it is reset with the rest.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rq_pipe[i] <= '0;
      end
    end else begin
      wbin         <= wbin_next;
      wptr_gray    <= wgray_next;
      wfull        <= (wgray_next == full_match);
      walmost_full <= (level_next >= PW'(ALMOST_FULL_TH));
      wfill_level  <= level_next;
      if (winc && wfull) begin
        woverflow <= 1'b1;
      end
      // NOTE: non-blocking assignments make each stage take the previous stage's old value.
      rq_pipe[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rq_pipe[i] <= rq_pipe[i-1];
      end
    end
  end

endmodule
